// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ valid/ready requesters.
// Optional statistics counters are enabled by defining ALU_ARB_STATS_EN.
package alu_share_arbiter_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_op_t;
endpackage

module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int GRANT_W = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  alu_op_t            req_alu_op [NUM_REQ],
    input  word_t              req_in_a   [NUM_REQ],
    input  word_t              req_in_b   [NUM_REQ],
    output logic [NUM_REQ-1:0] rsp_valid,
    input  logic [NUM_REQ-1:0] rsp_ready,
    output word_t              rsp_result,
    output logic               rsp_zero,
    output alu_op_t            alu_op,
    output word_t              alu_in_a,
    output word_t              alu_in_b,
    input  word_t              alu_result,
    input  logic               alu_zero,
    output logic               busy,
    output logic [GRANT_W-1:0] grant_id
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]        stat_grant_cnt [NUM_REQ],
    output logic [15:0]        stat_stall_cnt
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]         state;
    logic [GRANT_W-1:0] last_grant;
    alu_op_t            op_q;
    word_t              a_q;
    word_t              b_q;
    word_t              result_q;
    logic               zero_q;

    logic [GRANT_W-1:0] arb_base;
    logic [GRANT_W-1:0] arb_winner;
    logic [GRANT_W-1:0] cand;
    logic               arb_en;
    logic               arb_found;

    // In RESP the search already uses the priority the pending handshake will install.
    always_comb begin
        arb_base   = (state == ST_RESP) ? grant_id : last_grant;
        arb_en     = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready[grant_id]);
        arb_found  = 1'b0;
        arb_winner = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GRANT_W'((int'(arb_base) + k) % NUM_REQ);
            if (!arb_found && req_valid[cand]) begin
                arb_found  = 1'b1;
                arb_winner = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (arb_en && arb_found) begin
            req_ready[arb_winner] = 1'b1;
        end
        if (state == ST_RESP) begin
            rsp_valid[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_W'(NUM_REQ - 1);
            grant_id   <= '0;
            op_q       <= ALU_ADD;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        op_q     <= req_alu_op[arb_winner];
                        a_q      <= req_in_a[arb_winner];
                        b_q      <= req_in_b[arb_winner];
                        grant_id <= arb_winner;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    result_q <= alu_result;
                    zero_q   <= alu_zero;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[grant_id]) begin
                        last_grant <= grant_id;
                        if (arb_found) begin
                            op_q     <= req_alu_op[arb_winner];
                            a_q      <= req_in_a[arb_winner];
                            b_q      <= req_in_b[arb_winner];
                            grant_id <= arb_winner;
                            state    <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign alu_op     = op_q;
    assign alu_in_a   = a_q;
    assign alu_in_b   = b_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign busy       = (state == ST_ISSUE) || (state == ST_RESP);

`ifdef ALU_ARB_STATS_EN
    logic any_stall;

    always_comb begin
        any_stall = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !req_ready[i]) begin
                any_stall = 1'b1;
            end
        end
    end

    // Counters stick at 0xFFFF rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_stall_cnt <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_grant_cnt[i] <= '0;
            end
        end else begin
            if (any_stall && (stat_stall_cnt != 16'hFFFF)) begin
                stat_stall_cnt <= stat_stall_cnt + 16'd1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && (stat_grant_cnt[i] != 16'hFFFF)) begin
                    stat_grant_cnt[i] <= stat_grant_cnt[i] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with two requesters and a behavioural ALU.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    alu_op_t    req_alu_op [2];
    word_t      req_in_a   [2];
    word_t      req_in_b   [2];
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    word_t      rsp_result;
    logic       rsp_zero;
    alu_op_t    alu_op;
    word_t      alu_in_a;
    word_t      alu_in_b;
    word_t      alu_result;
    logic       alu_zero;
    logic       busy;
    logic       grant_id;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_grant_cnt [2];
    logic [15:0] stat_stall_cnt;
`endif

    int compared;
    int mismatched;

    alu_share_arbiter #(.NUM_REQ(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_alu_op (req_alu_op),
        .req_in_a   (req_in_a),
        .req_in_b   (req_in_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .alu_op     (alu_op),
        .alu_in_a   (alu_in_a),
        .alu_in_b   (alu_in_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy),
        .grant_id   (grant_id)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grant_cnt (stat_grant_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared ALU instance.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = alu_in_a + alu_in_b;
            ALU_SUB: alu_result = alu_in_a - alu_in_b;
            ALU_AND: alu_result = alu_in_a & alu_in_b;
            ALU_OR:  alu_result = alu_in_a | alu_in_b;
            ALU_XOR: alu_result = alu_in_a ^ alu_in_b;
            ALU_SLT: alu_result = {31'd0, $signed(alu_in_a) < $signed(alu_in_b)};
            ALU_SLL: alu_result = alu_in_a << alu_in_b[4:0];
            ALU_SRL: alu_result = alu_in_a >> alu_in_b[4:0];
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rdy);
        req_valid = valid;
        rsp_ready = rdy;
        #1;
    endtask

    task automatic setOperands(input int idx, input alu_op_t op, input word_t a, input word_t b);
        req_alu_op[idx] = op;
        req_in_a[idx]   = a;
        req_in_b[idx]   = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic exp_grant [4];
    word_t exp_result [4];

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        setOperands(0, ALU_ADD, 32'd0, 32'd0);
        setOperands(1, ALU_ADD, 32'd0, 32'd0);
        applyStimulus(2'b00, 2'b11);

        step();
        step();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_grant", grant_id, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_req_ready", req_ready, 0);
        checkOutput("reset_result", rsp_result, 0);
        checkOutput("reset_alu_a", alu_in_a, 0);
        rst_n = 1'b1;
        step();
        checkOutput("idle_no_req_ready", req_ready, 0);

        $display("[TB] single op");
        setOperands(0, ALU_ADD, 32'h5, 32'h7);
        applyStimulus(2'b01, 2'b11);
        checkOutput("single_req_ready", req_ready, 2'b01);
        step();
        applyStimulus(2'b00, 2'b11);
        checkOutput("single_issue_busy", busy, 1);
        checkOutput("single_issue_rsp_valid", rsp_valid, 0);
        checkOutput("single_issue_req_ready", req_ready, 0);
        checkOutput("single_issue_alu_a", alu_in_a, 32'h5);
        step();
        checkOutput("single_rsp_valid", rsp_valid, 2'b01);
        checkOutput("single_result", rsp_result, 32'h0000000C);
        checkOutput("single_zero", rsp_zero, 0);
        checkOutput("single_grant", grant_id, 0);
        step();
        checkOutput("single_back_idle", busy, 0);
        checkOutput("single_rsp_clear", rsp_valid, 0);

        $display("[TB] zero flag");
        setOperands(1, ALU_SUB, 32'h10, 32'h10);
        applyStimulus(2'b10, 2'b11);
        checkOutput("zero_req_ready", req_ready, 2'b10);
        step();
        applyStimulus(2'b00, 2'b11);
        step();
        checkOutput("zero_rsp_valid", rsp_valid, 2'b10);
        checkOutput("zero_result", rsp_result, 32'h0);
        checkOutput("zero_flag", rsp_zero, 1);
        checkOutput("zero_grant", grant_id, 1);
        step();

        $display("[TB] contention");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        setOperands(0, ALU_ADD, 32'h1, 32'h2);
        setOperands(1, ALU_XOR, 32'h0000F0F0, 32'h00000FF0);
        exp_grant[0] = 1'b0; exp_result[0] = 32'h3;
        exp_grant[1] = 1'b1; exp_result[1] = 32'hFF00;
        exp_grant[2] = 1'b0; exp_result[2] = 32'h3;
        exp_grant[3] = 1'b1; exp_result[3] = 32'hFF00;
        applyStimulus(2'b11, 2'b11);
        checkOutput("cont_first_ready", req_ready, 2'b01);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("cont_issue_ready", req_ready, 0);
            step();
            checkOutput("cont_grant", grant_id, exp_grant[i]);
            checkOutput("cont_rsp_valid", rsp_valid, exp_grant[i] ? 2'b10 : 2'b01);
            checkOutput("cont_result", rsp_result, exp_result[i]);
            if (i < 3) begin
                checkOutput("cont_next_ready", req_ready, exp_grant[i] ? 2'b01 : 2'b10);
            end
        end
        applyStimulus(2'b00, 2'b11);
        step();
        checkOutput("cont_drain_idle", busy, 0);

        $display("[TB] response backpressure");
        setOperands(0, ALU_ADD, 32'h5, 32'h7);
        setOperands(1, ALU_SUB, 32'h10, 32'h10);
        applyStimulus(2'b01, 2'b10);
        checkOutput("bp_req0_ready", req_ready, 2'b01);
        step();
        applyStimulus(2'b10, 2'b10);
        step();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_rsp_valid", rsp_valid, 2'b01);
            checkOutput("bp_hold_result", rsp_result, 32'h0000000C);
            checkOutput("bp_hold_req_ready", req_ready, 0);
            checkOutput("bp_hold_busy", busy, 1);
            step();
        end
        applyStimulus(2'b10, 2'b01);
        checkOutput("bp_release_ready", req_ready, 2'b10);
        step();
        applyStimulus(2'b00, 2'b00);
        checkOutput("bp_issue_grant", grant_id, 1);
        checkOutput("bp_issue_rsp_valid", rsp_valid, 0);
        step();
        checkOutput("bp_rsp1_valid", rsp_valid, 2'b10);
        checkOutput("bp_rsp1_zero", rsp_zero, 1);

        $display("[TB] reset in RESP");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_grant", grant_id, 0);
        checkOutput("rst_result", rsp_result, 0);
        checkOutput("rst_zero", rsp_zero, 0);
        checkOutput("rst_alu_b", alu_in_b, 0);
        setOperands(0, ALU_ADD, 32'h1, 32'h2);
        applyStimulus(2'b11, 2'b11);
        checkOutput("rst_prio_ready", req_ready, 2'b01);
        step();
        applyStimulus(2'b00, 2'b11);
        step();
        checkOutput("rst_after_grant", grant_id, 0);
        checkOutput("rst_after_rsp_valid", rsp_valid, 2'b01);
        checkOutput("rst_after_result", rsp_result, 32'h3);
`ifdef ALU_ARB_STATS_EN
        checkOutput("stat_grant0", stat_grant_cnt[0], 1);
        checkOutput("stat_grant1", stat_grant_cnt[1], 0);
        checkOutput("stat_stall", stat_stall_cnt, 1);
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (alu_op_t op, word_t in_a/in_b, word_t result, zero) between NUM_REQ requesters, e.g. the execute stage and a debug/self-test port.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Grants are round-robin. Operands and results are registered, so the ALU sees stable inputs and each requester sees a stable response.
- Sits between the requesters and the ALU instance in the core top level.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- GRANT_W, $clog2(NUM_REQ), width of the grant index (derived; do not override).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accept; one-hot or zero.
- req_alu_op  in  NUM_REQ x alu_op_t  per-requester operation.
- req_in_a  in  NUM_REQ x 32  per-requester operand A (word_t).
- req_in_b  in  NUM_REQ x 32  per-requester operand B (word_t).
- rsp_valid  out  NUM_REQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_result  out  32  shared registered result; meaningful only with rsp_valid.
- rsp_zero  out  1  shared registered zero flag.
- alu_op  out  alu_op_t  to ALU.
- alu_in_a  out  32  to ALU.
- alu_in_b  out  32  to ALU.
- alu_result  in  32  from ALU.
- alu_zero  in  1  from ALU.
- busy  out  1  high in ISSUE or RESP.
- grant_id  out  GRANT_W  index of the current or last granted requester.

Behaviour:
- Reset (rst_n low at an edge): state=IDLE; operand regs, result regs, grant_id = 0; last_grant = NUM_REQ-1, so requester 0 has first priority. All outputs derived from these registers take their reset values.
- Priority: the search starts at (last_grant+1) mod NUM_REQ and ascends with wrap. The first requester with req_valid high wins.
- IDLE:
  - req_ready[winner] is combinational, same cycle as req_valid.
  - On a handshake, capture op, a and b into the operand regs, grant_id <= winner, go to ISSUE.
  - No valid requests: stay in IDLE, req_ready = 0.
- ISSUE (1 cycle):
  - alu_op/alu_in_a/alu_in_b come from the operand regs (they always do; the ALU inputs change only on a capture).
  - Capture alu_result and alu_zero into the result regs, go to RESP.
- RESP:
  - rsp_valid[grant_id] = 1. rsp_result and rsp_zero are held stable until the handshake.
  - On rsp_ready[grant_id]: last_grant <= grant_id.
  - In the same cycle, run arbitration using the updated priority (the search starts at grant_id+1). If a winner exists, assert its req_ready, capture its request and go to ISSUE; otherwise go to IDLE.
- Latency: request accepted at cycle N, rsp_valid high at N+2.
  - Back-to-back throughput is one op per 2 cycles while responses are consumed immediately.
- Fairness: a continuously valid requester is granted within NUM_REQ-1 grants to other requesters.
- req_ready is never asserted in ISSUE, or in RESP before the response handshake. rsp_ready on a non-granted index is ignored.
- A requester may drop req_valid before acceptance. No transaction is recorded and no error is raised.
- Simultaneous requests in IDLE: exactly one req_ready, following the rotating priority.
- Reset mid-ISSUE or mid-RESP: the transaction is discarded, no response is issued, and the arbiter returns to IDLE with requester 0 first.
- The result width is exactly the ALU's 32 bits; no extension or truncation.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds output stat_grant_cnt (NUM_REQ x 16) and output stat_stall_cnt (16).
  - stat_grant_cnt[i] increments on each request handshake of requester i.
  - stat_stall_cnt increments each cycle any requester has req_valid high with req_ready low.
  - All counters saturate at 0xFFFF and clear on reset.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Single op: req0 add, a=0x00000005, b=0x00000007, accepted at cycle N -> rsp_valid[0] at N+2, rsp_result=0x0000000C, rsp_zero=0, grant_id=0.
- Zero flag: req1 sub, a=b=0x00000010 -> rsp_result=0x00000000, rsp_zero=1, rsp_valid only on index 1.
- Contention: req0 and req1 both valid continuously from reset -> grant order 0,1,0,1; each rsp_result matches its own operands.
- Response backpressure: hold rsp_ready[0]=0 for 5 cycles -> rsp_valid[0] and rsp_result stay stable, req_ready stays 0, busy=1; release -> the pending req1 is accepted in the same cycle.
- Reset in RESP: assert rst_n=0 for one edge while rsp_valid[1]=1 -> all outputs and registers return to 0 next cycle, no response on index 1, and the next simultaneous requests are granted to requester 0.
- Stats (ALU_ARB_STATS_EN defined): 3 ops from req0 and 2 from req1 under contention -> stat_grant_cnt = {2,3} (index 1, index 0); stat_stall_cnt equals the counted blocked cycles; forcing 0xFFFF grants shows saturation at 0xFFFF.
